// File: rtl/round_counter_if.sv
// Control and status bundle for round_counter: the master drives the run controls
// and the slave reports the count, run state and terminal events.
interface round_counter_if #(
    parameter int unsigned WIDTH  = 6,
    parameter int unsigned WRAP_W = 8
);
    logic              enable;
    logic              start;
    logic              abort;
    logic              load;
    logic [WIDTH-1:0]  load_value;
    logic [WIDTH-1:0]  q;
    logic              busy;
    logic              tc;
    logic              done;
    logic [WRAP_W-1:0] wraps;

    modport master (
        output enable, start, abort, load, load_value,
        input  q, busy, tc, done, wraps
    );

    modport slave (
        input  enable, start, abort, load, load_value,
        output q, busy, tc, done, wraps
    );
endinterface

// File: rtl/round_counter.sv
// Parametrised round/step counter with one-shot or free-running terminal behaviour,
// start/abort/load control, a one-cycle done pulse and a wrap counter.
module round_counter #(
    parameter int unsigned WIDTH    = 6,
    parameter int unsigned LAST     = 63,
    parameter int unsigned STEP     = 1,
    parameter bit          FREE_RUN = 1'b0,
    parameter int unsigned WRAP_W   = 8
) (
    input logic           clock,
    input logic           reset,
    round_counter_if.slave bus
);
    typedef enum logic [0:0] {StIdle, StRun} state_e;

    localparam logic [WIDTH-1:0] LastW   = WIDTH'(LAST);
    localparam logic [WIDTH:0]   LastExt = (WIDTH + 1)'(LAST);
    localparam logic [WIDTH:0]   StepExt = (WIDTH + 1)'(STEP);

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  q_q, q_d;
    logic [WRAP_W-1:0] wraps_q, wraps_d;
    logic              done_q, done_d;
    logic [WIDTH:0]    nxt;
    logic [WIDTH-1:0]  load_clamped;

    assign load_clamped = (bus.load_value > LastW) ? LastW : bus.load_value;

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        wraps_d = wraps_q;
        done_d  = 1'b0;
        // One extra bit so a step past LAST is seen rather than wrapping silently.
        nxt     = {1'b0, q_q} + StepExt;
        if (bus.load) begin
            // Load owns q; a concurrent abort/start only moves the state.
            q_d = load_clamped;
            if (bus.abort) begin
                state_d = StIdle;
            end else if (bus.start && state_q == StIdle) begin
                state_d = StRun;
            end
        end else if (bus.abort) begin
            state_d = StIdle;
        end else if (state_q == StIdle) begin
            if (bus.start) begin
                state_d = StRun;
                q_d     = '0;
                wraps_d = '0;
            end
        end else if (bus.enable) begin
            if (nxt <= LastExt) begin
                q_d = nxt[WIDTH-1:0];
            end else begin
                done_d  = 1'b1;
                wraps_d = wraps_q + WRAP_W'(1);
                if (FREE_RUN) begin
                    q_d = '0;
                end else begin
                    q_d     = LastW;
                    state_d = StIdle;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= StIdle;
            q_q     <= '0;
            wraps_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            wraps_q <= wraps_d;
            done_q  <= done_d;
        end
    end

    assign bus.q     = q_q;
    assign bus.busy  = (state_q == StRun);
    assign bus.tc    = (q_q == LastW);
    assign bus.done  = done_q;
    assign bus.wraps = wraps_q;
endmodule

// File: tb/tb_round_counter.sv
// Drives five differently parametrised round_counter instances with shared stimulus and
// compares each against an arithmetic reference model every cycle.
module tb_round_counter;
    localparam int N = 5;
    localparam int LASTP[N] = '{63, 9, 10, 0, 63};
    localparam int STEPP[N] = '{1, 3, 4, 1, 1};
    localparam int FREEP[N] = '{0, 1, 0, 1, 0};
    localparam int WIDP[N]  = '{6, 4, 4, 3, 7};
    localparam int WWP[N]   = '{8, 3, 8, 4, 8};

    logic clock = 1'b0;
    logic rst, en, st, ab, ld;
    logic [6:0] lv;

    always #5 clock = ~clock;

    round_counter_if #(.WIDTH(6), .WRAP_W(8)) u0 ();
    round_counter_if #(.WIDTH(4), .WRAP_W(3)) u1 ();
    round_counter_if #(.WIDTH(4), .WRAP_W(8)) u2 ();
    round_counter_if #(.WIDTH(3), .WRAP_W(4)) u3 ();
    round_counter_if #(.WIDTH(7), .WRAP_W(8)) u4 ();

    round_counter #(.WIDTH(6), .LAST(63), .STEP(1), .FREE_RUN(1'b0), .WRAP_W(8))
        dut0 (.clock(clock), .reset(rst), .bus(u0));
    round_counter #(.WIDTH(4), .LAST(9), .STEP(3), .FREE_RUN(1'b1), .WRAP_W(3))
        dut1 (.clock(clock), .reset(rst), .bus(u1));
    round_counter #(.WIDTH(4), .LAST(10), .STEP(4), .FREE_RUN(1'b0), .WRAP_W(8))
        dut2 (.clock(clock), .reset(rst), .bus(u2));
    round_counter #(.WIDTH(3), .LAST(0), .STEP(1), .FREE_RUN(1'b1), .WRAP_W(4))
        dut3 (.clock(clock), .reset(rst), .bus(u3));
    round_counter #(.WIDTH(7), .LAST(63), .STEP(1), .FREE_RUN(1'b0), .WRAP_W(8))
        dut4 (.clock(clock), .reset(rst), .bus(u4));

    assign {u0.enable, u0.start, u0.abort, u0.load} = {en, st, ab, ld};
    assign {u1.enable, u1.start, u1.abort, u1.load} = {en, st, ab, ld};
    assign {u2.enable, u2.start, u2.abort, u2.load} = {en, st, ab, ld};
    assign {u3.enable, u3.start, u3.abort, u3.load} = {en, st, ab, ld};
    assign {u4.enable, u4.start, u4.abort, u4.load} = {en, st, ab, ld};
    assign u0.load_value = lv[5:0];
    assign u1.load_value = lv[3:0];
    assign u2.load_value = lv[3:0];
    assign u3.load_value = lv[2:0];
    assign u4.load_value = lv;

    int aq[N], aw[N], abusy[N], atc[N], adone[N];
    assign aq[0] = int'(u0.q);  assign aw[0] = int'(u0.wraps);
    assign aq[1] = int'(u1.q);  assign aw[1] = int'(u1.wraps);
    assign aq[2] = int'(u2.q);  assign aw[2] = int'(u2.wraps);
    assign aq[3] = int'(u3.q);  assign aw[3] = int'(u3.wraps);
    assign aq[4] = int'(u4.q);  assign aw[4] = int'(u4.wraps);
    assign abusy = '{int'(u0.busy), int'(u1.busy), int'(u2.busy), int'(u3.busy), int'(u4.busy)};
    assign atc   = '{int'(u0.tc), int'(u1.tc), int'(u2.tc), int'(u3.tc), int'(u4.tc)};
    assign adone = '{int'(u0.done), int'(u1.done), int'(u2.done), int'(u3.done), int'(u4.done)};

    // Reference model: running flag, count, wrap count and done pulse per instance.
    int mq[N], mw[N], mrun[N], mdone[N];
    int nvec = 0;
    int nmis = 0;

    task automatic chk(input string nm, input int i, input int act, input int exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s dut%0d got=%0d want=%0d at %0t", nm, i, act, exp, $time);
        end
    endtask

    task automatic model_edge(input int i);
        int lvm;
        lvm = int'(lv) & ((1 << WIDP[i]) - 1);
        if (!rst) begin
            mq[i] = 0; mw[i] = 0; mrun[i] = 0; mdone[i] = 0;
        end else begin
            mdone[i] = 0;
            if (ld) begin
                mq[i] = (lvm > LASTP[i]) ? LASTP[i] : lvm;
                if (ab) mrun[i] = 0;
                else if (st) mrun[i] = 1;
            end else if (ab) begin
                mrun[i] = 0;
            end else if (mrun[i] == 0) begin
                if (st) begin
                    mrun[i] = 1; mq[i] = 0; mw[i] = 0;
                end
            end else if (en) begin
                if (mq[i] + STEPP[i] <= LASTP[i]) begin
                    mq[i] = mq[i] + STEPP[i];
                end else begin
                    mdone[i] = 1;
                    mw[i] = (mw[i] + 1) % (1 << WWP[i]);
                    if (FREEP[i] != 0) mq[i] = 0;
                    else begin
                        mq[i] = LASTP[i]; mrun[i] = 0;
                    end
                end
            end
        end
    endtask

    task automatic tick();
        for (int i = 0; i < N; i++) model_edge(i);
        @(posedge clock);
        #1;
        for (int i = 0; i < N; i++) begin
            chk("q", i, aq[i], mq[i]);
            chk("busy", i, abusy[i], mrun[i]);
            chk("tc", i, atc[i], int'(mq[i] == LASTP[i]));
            chk("done", i, adone[i], mdone[i]);
            chk("wraps", i, aw[i], mw[i]);
        end
    endtask

    task automatic idle_inputs();
        rst = 1'b1; en = 1'b0; st = 1'b0; ab = 1'b0; ld = 1'b0; lv = '0;
    endtask

    typedef struct {
        bit rst, en, st, ab, ld;
        int lv;
        int q, busy, done, wr;
    } vec_t;
    vec_t tbl[15];

    initial begin
        for (int i = 0; i < N; i++) begin
            mq[i] = 0; mw[i] = 0; mrun[i] = 0; mdone[i] = 0;
        end
        //          rst en st ab ld lv    q busy done wr   (expected for dut0)
        tbl[0]  = '{0, 0, 0, 0, 0, 0,    0, 0, 0, 0};
        tbl[1]  = '{0, 1, 1, 0, 1, 5,    0, 0, 0, 0};
        tbl[2]  = '{1, 0, 1, 0, 0, 0,    0, 1, 0, 0};
        tbl[3]  = '{1, 1, 0, 0, 0, 0,    1, 1, 0, 0};
        tbl[4]  = '{1, 1, 1, 0, 0, 0,    2, 1, 0, 0};
        tbl[5]  = '{1, 0, 0, 0, 0, 0,    2, 1, 0, 0};
        tbl[6]  = '{1, 1, 0, 1, 0, 0,    2, 0, 0, 0};
        tbl[7]  = '{1, 0, 0, 1, 0, 0,    2, 0, 0, 0};
        tbl[8]  = '{1, 0, 0, 0, 1, 40,   40, 0, 0, 0};
        tbl[9]  = '{1, 0, 1, 0, 0, 0,    0, 1, 0, 0};
        tbl[10] = '{1, 1, 0, 0, 1, 62,   62, 1, 0, 0};
        tbl[11] = '{1, 1, 0, 0, 0, 0,    63, 1, 0, 0};
        tbl[12] = '{1, 1, 0, 0, 0, 0,    63, 0, 1, 1};
        tbl[13] = '{1, 1, 0, 0, 0, 0,    63, 0, 0, 1};
        tbl[14] = '{1, 0, 1, 0, 0, 0,    0, 1, 0, 0};

        idle_inputs();
        for (int v = 0; v < 15; v++) begin
            rst = tbl[v].rst; en = tbl[v].en; st = tbl[v].st;
            ab = tbl[v].ab; ld = tbl[v].ld; lv = 7'(tbl[v].lv);
            tick();
            chk("tbl_q", v, aq[0], tbl[v].q);
            chk("tbl_busy", v, abusy[0], tbl[v].busy);
            chk("tbl_done", v, adone[0], tbl[v].done);
            chk("tbl_wraps", v, aw[0], tbl[v].wr);
        end

        // Full one-shot run with enable held high.
        idle_inputs();
        rst = 1'b0; tick(); tick();
        rst = 1'b1; st = 1'b1; tick();
        chk("os_start_q", 0, aq[0], 0);
        chk("os_start_busy", 0, abusy[0], 1);
        st = 1'b0; en = 1'b1;
        for (int k = 1; k <= 64; k++) begin
            tick();
            if (k < 64) chk("os_q", k, aq[0], k);
            if (k == 63) chk("os_tc", k, atc[0], 1);
            chk("os_done", k, adone[0], int'(k == 64));
        end
        chk("os_end_busy", 0, abusy[0], 0);
        chk("os_end_q", 0, aq[0], 63);
        chk("os_end_wraps", 0, aw[0], 1);
        en = 1'b0; tick();
        chk("os_done_clear", 0, adone[0], 0);

        // Enable toggling: 64 enabled edges take 128 clocks.
        st = 1'b1; tick(); st = 1'b0;
        for (int c = 0; c < 128; c++) begin
            en = (c % 2 == 0);
            tick();
            chk("gate_done", c, adone[0], int'(c == 126));
        end
        en = 1'b0;

        // Free-running LAST=9 STEP=3 instance.
        ab = 1'b1; tick(); ab = 1'b0;
        st = 1'b1; tick(); st = 1'b0; en = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk("fr_q", k, aq[1], (k % 4) * 3);
            chk("fr_done", k, adone[1], int'(k % 4 == 0));
            chk("fr_wraps", k, aw[1], k / 4);
            chk("fr_busy", k, abusy[1], 1);
        end

        // Abort at 20, restart, start ignored mid-run.
        en = 1'b0; ab = 1'b1; tick(); ab = 1'b0;
        st = 1'b1; tick(); st = 1'b0; en = 1'b1;
        for (int k = 0; k < 20; k++) tick();
        chk("ab_pre_q", 0, aq[0], 20);
        ab = 1'b1; tick();
        chk("ab_q", 0, aq[0], 20);
        chk("ab_busy", 0, abusy[0], 0);
        chk("ab_done", 0, adone[0], 0);
        ab = 1'b0; en = 1'b0; tick();
        st = 1'b1; tick();
        chk("rs_q", 0, aq[0], 0);
        chk("rs_wraps", 0, aw[0], 0);
        chk("rs_busy", 0, abusy[0], 1);
        st = 1'b0; en = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        st = 1'b1; tick();
        chk("st_ign_q", 0, aq[0], 6);
        st = 1'b0;

        // Load clamp, load on a terminal edge, load while idle.
        en = 1'b0; ld = 1'b1; lv = 7'd70; tick();
        chk("ld_clamp_q", 4, aq[4], 63);
        chk("ld_clamp_busy", 4, abusy[4], 1);
        lv = 7'd63; tick();
        en = 1'b1; lv = 7'd10; tick();
        chk("ld_term_q", 0, aq[0], 10);
        chk("ld_term_done", 0, adone[0], 0);
        chk("ld_term_busy", 0, abusy[0], 1);
        ld = 1'b0; en = 1'b0; ab = 1'b1; tick(); ab = 1'b0;
        ld = 1'b1; lv = 7'd33; tick();
        chk("ld_idle_q", 0, aq[0], 33);
        chk("ld_idle_busy", 0, abusy[0], 0);
        ld = 1'b0;

        // Reset mid-run with every other control asserted.
        st = 1'b1; tick(); st = 1'b0; en = 1'b1;
        for (int k = 0; k < 40; k++) tick();
        chk("mr_pre_q", 0, aq[0], 40);
        rst = 1'b0; st = 1'b1; ld = 1'b1; lv = 7'd5; tick();
        chk("mr_q", 0, aq[0], 0);
        chk("mr_busy", 0, abusy[0], 0);
        chk("mr_done", 0, adone[0], 0);
        chk("mr_wraps", 0, aw[0], 0);
        idle_inputs();

        // Randomised traffic against the model; load and start are kept apart.
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(63) != 0);
            en  = ($urandom_range(3) != 0);
            st  = ($urandom_range(7) == 0);
            ab  = ($urandom_range(31) == 0);
            ld  = ($urandom_range(15) == 0);
            lv  = 7'($urandom);
            if (ld) st = 1'b0;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule

// File: doc/round_counter.md
Name: round_counter

Overview:
- Parametrised successor of the fixed 6-bit T-flip-flop counter, used as the SHA-256 round index (0..63) and as the generic step counter in the miner datapath.
- Adds the following over the fixed counter:
  - configurable width, terminal value and step
  - one-shot and free-running modes
  - start/abort control, synchronous load, enable gating
  - a one-cycle done pulse and a wrap counter

Parameters:
- WIDTH, 6, counter width in bits; must be >= 1.
- LAST, 63, terminal value; must satisfy 0 <= LAST <= 2^WIDTH-1.
- STEP, 1, increment per enabled cycle; must satisfy 1 <= STEP <= LAST+1.
- FREE_RUN, 0, mode select:
  - 0 = one-shot: stop at terminal.
  - 1 = free-run: wrap to 0 and keep counting.
- WRAP_W, 8, width of the wrap counter.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset, sampled on rising edge of clock.
- enable  in  1  count enable; q advances only when busy and enable are both high.
- start  in  1  begins a run from q=0; ignored while busy.
- abort  in  1  ends a run immediately; q holds its value, no done pulse.
- load  in  1  synchronous load of load_value into q; accepted in any state.
- load_value  in  WIDTH  value to load; values > LAST are clamped to LAST.
- q  out  WIDTH  current count, registered.
- busy  out  1  high while in state RUN, registered.
- tc  out  1  combinational, q == LAST.
- done  out  1  one-cycle pulse at each terminal event, registered.
- wraps  out  WRAP_W  number of terminal events since reset or start; modulo 2^WRAP_W.

Behaviour:
- States:
  - IDLE (busy=0)
  - RUN (busy=1)
- Reset (reset low at an edge): state IDLE, q=0, done=0, wraps=0. Outputs reflect this from the cycle after that edge. Reset overrides every other input.
- Priority per edge: reset > load > abort > start > count.
- done defaults to 0 on every edge unless a terminal event occurs on that edge.
- Load:
  - q <= min(load_value, LAST).
  - State, busy and wraps are unchanged.
  - A count or terminal event on the same edge is suppressed, so no done pulse.
  - start or abort on the same edge is still applied: state is updated, but q takes the load value.
- Abort while RUN: state <= IDLE, q holds, done=0. Abort while IDLE has no effect.
- Start while IDLE: state <= RUN, q <= 0, wraps <= 0. Start while RUN is ignored.
- Count: in RUN with enable high, compute nxt = q + STEP in WIDTH+1 bits (no silent overflow).
  - nxt <= LAST: q <= nxt.
  - nxt > LAST (terminal event): done <= 1, wraps <= wraps+1.
    - FREE_RUN=0: q <= LAST, state <= IDLE.
    - FREE_RUN=1: q <= 0, stay in RUN.
- enable low in RUN: q, state and wraps hold; done=0.
- Latency, STEP=1, LAST=63:
  - start sampled at edge E0 gives q=0, busy=1.
  - After the 63rd enabled edge, q=63 and tc=1.
  - The 64th enabled edge is the terminal event: done=1 for exactly one cycle.
    - One-shot: busy=0 in that same cycle.
    - Free-run: q=0.
- Non-aligned STEP (e.g. LAST=10, STEP=4): sequence 0,4,8, then the terminal event.
  - One-shot: q clamps to 10.
  - Free-run: q goes to 0.
- LAST=0: every enabled RUN edge is a terminal event.
- Reset held low across any number of edges keeps all outputs at reset values. Reset mid-run discards the run with no done pulse.

Test Plan:
- Defaults, one-shot:
  - reset low 2 cycles, release, start pulse, enable held high.
  - q counts 0..63, tc=1 when q=63, done=1 for one cycle after the 64th enabled edge.
  - busy falls in that same cycle; q stays 63; wraps=1.
- Enable gating: same setup with enable toggling every other cycle → q advances only on enabled edges; done after 64 enabled edges (128 clocks).
- FREE_RUN=1, LAST=9, STEP=3:
  - start, enable high.
  - q sequence 0,3,6,9,0,3,…; done pulses every 4th enabled edge.
  - wraps = 1, 2, 3 on successive terminal events; busy stays 1.
- Abort and restart:
  - abort at q=20 → busy=0, q=20, no done.
  - Later start → q=0, wraps=0, counting resumes.
  - start asserted at q=5 during a run → ignored, q continues 6.
- Load:
  - load_value=70 with LAST=63 → q=63.
  - load with load_value=10 on the same edge as a terminal event → q=10, done stays 0.
  - load in IDLE → q updates, busy stays 0.
- Reset mid-run: reset low at q=40 → the next cycle shows q=0, busy=0, done=0, wraps=0, even with start, load and enable all high on that edge.
